// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One operation in flight at a time: accept -> evaluate -> hold response.
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_op1,
    input  logic [WIDTH-1:0] req0_op2,
    input  logic [2:0]       req0_func,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_op1,
    input  logic [WIDTH-1:0] req1_op2,
    input  logic [2:0]       req1_func,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [2:0]       alu_func,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    input  logic             alu_zero,
    input  logic             alu_equals,
    input  logic             alu_above,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_overflow,
    output logic             rsp_zero,
    output logic             rsp_equals,
    output logic             rsp_above
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic             last_grant_reg;
    logic             tag_reg;
    logic [WIDTH-1:0] op1_reg, op2_reg;
    logic [2:0]       func_reg;
    logic             grant;
    logic             accept;

    logic [WIDTH-1:0] rsp_result_reg;
    logic             rsp_id_reg;
    logic             rsp_overflow_reg, rsp_zero_reg, rsp_equals_reg, rsp_above_reg;

    // Contention goes to the requester not served last; a lone requester always wins.
    always_comb begin
        grant = req1_valid;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant_reg;
        end
    end

    // Readies are gated by rst_n so nothing is accepted while reset is held.
    assign req0_ready = rst_n && (state_reg == IDLE) && !grant && req0_valid;
    assign req1_ready = rst_n && (state_reg == IDLE) &&  grant && req1_valid;
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)    state_next = EXEC;
            EXEC:                   state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            tag_reg        <= 1'b0;
            op1_reg        <= '0;
            op2_reg        <= '0;
            func_reg       <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                last_grant_reg <= grant;
                tag_reg        <= grant;
                op1_reg        <= grant ? req1_op1  : req0_op1;
                op2_reg        <= grant ? req1_op2  : req0_op2;
                func_reg       <= grant ? req1_func : req0_func;
            end
        end
    end

    // Response registers only load at the end of EXEC, so they stay stable through RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result_reg   <= '0;
            rsp_id_reg       <= 1'b0;
            rsp_overflow_reg <= 1'b0;
            rsp_zero_reg     <= 1'b0;
            rsp_equals_reg   <= 1'b0;
            rsp_above_reg    <= 1'b0;
        end else if (state_reg == EXEC) begin
            rsp_result_reg   <= alu_result;
            rsp_id_reg       <= tag_reg;
            rsp_overflow_reg <= alu_overflow;
            rsp_zero_reg     <= alu_zero;
            rsp_equals_reg   <= alu_equals;
            rsp_above_reg    <= alu_above;
        end
    end

    assign alu_op1      = op1_reg;
    assign alu_op2      = op2_reg;
    assign alu_func     = func_reg;
    assign rsp_valid    = (state_reg == RESP);
    assign rsp_id       = rsp_id_reg;
    assign rsp_result   = rsp_result_reg;
    assign rsp_overflow = rsp_overflow_reg;
    assign rsp_zero     = rsp_zero_reg;
    assign rsp_equals   = rsp_equals_reg;
    assign rsp_above    = rsp_above_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, directed corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_alu_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [2:0]   req0_func, req1_func;
    logic [W-1:0] alu_op1, alu_op2, alu_result;
    logic [2:0]   alu_func;
    logic         alu_overflow, alu_zero, alu_equals, alu_above;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [W-1:0] rsp_result;
    logic         rsp_overflow, rsp_zero, rsp_equals, rsp_above;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_func(req0_func),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_func(req1_func),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_func(alu_func),
        .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_zero(alu_zero),
        .alu_equals(alu_equals), .alu_above(alu_above),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_result(rsp_result), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
        .rsp_equals(rsp_equals), .rsp_above(rsp_above)
    );

    typedef struct packed {
        logic         ov;
        logic         z;
        logic         eq;
        logic         ab;
        logic [W-1:0] res;
    } alu_o_t;

    // Stand-in ALU attached to the DUT; also the oracle for expected responses.
    function automatic alu_o_t alu_model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] f);
        alu_o_t o;
        o = '0;
        case (f)
            3'd0: begin o.res = a + b; o.ov = (a[W-1] == b[W-1]) && (o.res[W-1] != a[W-1]); end
            3'd1: begin o.res = a - b; o.ov = (a[W-1] != b[W-1]) && (o.res[W-1] != a[W-1]); end
            3'd2: o.res = a & b;
            3'd3: o.res = a | b;
            3'd4: o.res = a ^ b;
            3'd5: o.res = a << b[4:0];
            3'd6: o.res = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: o.res = a;
        endcase
        o.z  = (o.res == '0);
        o.eq = (a == b);
        o.ab = (a > b);
        return o;
    endfunction

    alu_o_t alu_o;
    always_comb begin
        alu_o = alu_model(alu_op1, alu_op2, alu_func);
    end
    assign alu_result   = alu_o.res;
    assign alu_overflow = alu_o.ov;
    assign alu_zero     = alu_o.z;
    assign alu_equals   = alu_o.eq;
    assign alu_above    = alu_o.ab;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic         id;
        logic [W-1:0] op1, op2;
        logic [2:0]   func;
        logic [W-1:0] res;
        logic         ov, z, eq, ab;
    } vec_t;

    vec_t vecs[6];

    // Issue one op on a single port (starting at a negedge) and check the 3-cycle round trip.
    task automatic run_vec(input vec_t v);
        int waited;
        logic got;
        if (v.id) begin
            req1_valid = 1'b1; req1_op1 = v.op1; req1_op2 = v.op2; req1_func = v.func;
        end else begin
            req0_valid = 1'b1; req0_op1 = v.op1; req0_op2 = v.op2; req0_func = v.func;
        end
        rsp_ready = 1'b1;
        waited = 0;
        #1;
        got = v.id ? req1_ready : req0_ready;
        while (!got && waited < 10) begin
            @(negedge clk); #1;
            got = v.id ? req1_ready : req0_ready;
            waited++;
        end
        chk("vec_ready", {63'd0, got}, 64'd1);
        chk("vec_other_ready", {63'd0, (v.id ? req0_ready : req1_ready)}, 64'd0);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1 chk("vec_exec_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk); #1;
        chk("vec_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        chk("vec_rsp_id", {63'd0, rsp_id}, {63'd0, v.id});
        chk("vec_rsp_result", {32'd0, rsp_result}, {32'd0, v.res});
        chk("vec_rsp_flags", {60'd0, rsp_overflow, rsp_zero, rsp_equals, rsp_above},
            {60'd0, v.ov, v.z, v.eq, v.ab});
        $display("vec id=%0d op1=%h op2=%h func=%0d -> result=%h", v.id, v.op1, v.op2, v.func, rsp_result);
        @(negedge clk);
        #1 chk("vec_idle_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    endtask

    // Random-phase reference model state (transaction level, cycle-indexed).
    logic         pend[2];
    logic [W-1:0] pop1[2], pop2[2];
    logic [2:0]   pfunc[2];

    initial begin
        logic [W-1:0] c_op1[2];
        logic [W-1:0] e_res;
        logic         e_id;
        logic         m_lg, m_out, exp_g, exp_r0, exp_r1, exp_rv;
        int           m_acc;
        logic [W-1:0] m_a1, m_a2;
        logic [2:0]   m_f;
        alu_o_t       m_exp;
        logic         m_id;

        vecs[0] = '{1'b0, 32'd5,          32'd7,    3'd0, 32'd12,         1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 32'h7FFFFFFF,   32'd1,    3'd0, 32'h80000000,   1'b1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 32'd9,          32'd9,    3'd1, 32'd0,          1'b0, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b1, 32'h80000000,   32'd1,    3'd1, 32'h7FFFFFFF,   1'b1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 32'h0000F0F0,   32'h0FF0, 3'd2, 32'h000000F0,   1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1'b1, 32'd0,          32'd0,    3'd3, 32'd0,          1'b0, 1'b1, 1'b1, 1'b0};

        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b0;
        req0_op1 = 32'd11; req0_op2 = 32'd22; req0_func = 3'd0;
        req1_op1 = 32'd33; req1_op2 = 32'd44; req1_func = 3'd0;

        // Reset state, with both valids raised to prove readies stay low.
        @(negedge clk); #1;
        chk("rst_ready0", {63'd0, req0_ready}, 64'd0);
        chk("rst_ready1", {63'd0, req1_ready}, 64'd0);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_alu_ops", {alu_op1, alu_op2}, 64'd0);
        chk("rst_rsp", {27'd0, alu_func, rsp_id, rsp_overflow, rsp_zero, rsp_equals, rsp_above, rsp_result},
            64'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_vec(vecs[i]);
        end

        // Contention: both valid continuously; expect 0,1,0,1 after reset.
        do_reset();
        rsp_ready = 1'b1;
        c_op1[0] = 32'd100; c_op1[1] = 32'd200;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_op1 = c_op1[0]; req0_op2 = 32'd1; req0_func = 3'd0;
        req1_op1 = c_op1[1]; req1_op2 = 32'd2; req1_func = 3'd0;
        for (int k = 0; k < 4; k++) begin
            #1;
            e_id = k[0];
            chk("cont_ready0", {63'd0, req0_ready}, {63'd0, !e_id});
            chk("cont_ready1", {63'd0, req1_ready}, {63'd0, e_id});
            e_res = e_id ? (c_op1[1] + 32'd2) : (c_op1[0] + 32'd1);
            @(negedge clk);
            if (e_id) begin c_op1[1] = c_op1[1] + 32'd1000; req1_op1 = c_op1[1]; end
            else      begin c_op1[0] = c_op1[0] + 32'd1000; req0_op1 = c_op1[0]; end
            #1 chk("cont_exec_readies", {62'd0, req0_ready, req1_ready}, 64'd0);
            @(negedge clk); #1;
            chk("cont_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            chk("cont_rsp_id", {63'd0, rsp_id}, {63'd0, e_id});
            chk("cont_rsp_result", {32'd0, rsp_result}, {32'd0, e_res});
            $display("contention op %0d: id=%0d result=%0d", k, rsp_id, rsp_result);
            @(negedge clk);
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Backpressure: response held for 5 stalled cycles while req0 waits.
        @(negedge clk);
        rsp_ready = 1'b0;
        req1_valid = 1'b1; req1_op1 = 32'd3; req1_op2 = 32'd4; req1_func = 3'd0;
        #1 chk("bp_accept1", {63'd0, req1_ready}, 64'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_op1 = 32'd10; req0_op2 = 32'd20; req0_func = 3'd0;
        #1 chk("bp_exec_ready0", {63'd0, req0_ready}, 64'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_hold", {29'd0, rsp_valid, rsp_id, req0_ready, rsp_result}, {29'd0, 3'b110, 32'd7});
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1 chk("bp_release_ready0", {62'd0, rsp_valid, req0_ready}, 64'd2);
        @(negedge clk); #1;
        chk("bp_idle_accept0", {62'd0, rsp_valid, req0_ready}, 64'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk); #1;
        chk("bp_rsp2", {31'd0, rsp_valid, rsp_result}, {31'd0, 1'b1, 32'd30});
        chk("bp_rsp2_id", {63'd0, rsp_id}, 64'd0);
        $display("backpressure: second result=%0d id=%0d", rsp_result, rsp_id);
        @(negedge clk);

        // Reset during EXEC discards the op.
        req0_valid = 1'b1; req0_op1 = 32'd1; req0_op2 = 32'd2; req0_func = 3'd0;
        #1 chk("rm_accept0", {63'd0, req0_ready}, 64'd1);
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op1 = 32'd40; req1_op2 = 32'd2; req1_func = 3'd1;
        #2 rst_n = 1'b0;
        #1;
        chk("rm_immediate", {29'd0, rsp_valid, req0_ready, req1_ready, alu_op1}, 64'd0);
        chk("rm_immediate_rsp", {rsp_id, rsp_result}, 64'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("rm_held", {61'd0, rsp_valid, req0_ready, req1_ready}, 64'd0);
        end
        rst_n = 1'b1;
        #1 chk("rm_after_ready1", {63'd0, req1_ready}, 64'd1);
        @(negedge clk);
        req1_valid = 1'b0;
        #1 chk("rm_no_stale_rsp", {63'd0, rsp_valid}, 64'd0);
        @(negedge clk); #1;
        chk("rm_rsp", {30'd0, rsp_valid, rsp_id, rsp_result}, {30'd0, 2'b11, 32'd38});
        $display("reset mid-op: new op id=%0d result=%0d", rsp_id, rsp_result);
        @(negedge clk);

        // Operand isolation: change input after accept.
        req0_valid = 1'b1; req0_op1 = 32'd100; req0_op2 = 32'd1; req0_func = 3'd0;
        #1 chk("iso_accept", {63'd0, req0_ready}, 64'd1);
        @(negedge clk);
        req0_op1 = 32'd999; req0_valid = 1'b0;
        #1 chk("iso_alu_op1", {32'd0, alu_op1}, 64'd100);
        @(negedge clk); #1;
        chk("iso_rsp_result", {32'd0, rsp_result}, 64'd101);
        $display("isolation: result=%0d", rsp_result);
        @(negedge clk);

        // Randomized traffic vs. a transaction-level model.
        do_reset();
        m_lg = 1'b1; m_out = 1'b0; m_acc = 0; m_a1 = '0; m_a2 = '0; m_f = '0;
        m_exp = '0; m_id = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p] && $urandom_range(0, 2) == 0) begin
                    pend[p]  = 1'b1;
                    pop1[p]  = ($urandom_range(0, 3) == 0) ? 32'h7FFFFFF0 + $urandom_range(0, 31) : $urandom;
                    pop2[p]  = ($urandom_range(0, 3) == 0) ? pop1[p] : $urandom;
                    pfunc[p] = 3'($urandom_range(0, 7));
                end
            end
            req0_valid = pend[0]; req0_op1 = pop1[0]; req0_op2 = pop2[0]; req0_func = pfunc[0];
            req1_valid = pend[1]; req1_op1 = pop1[1]; req1_op2 = pop2[1]; req1_func = pfunc[1];
            rsp_ready = ($urandom_range(0, 4) != 0);
            #1;
            exp_g  = (pend[0] && pend[1]) ? !m_lg : pend[1];
            exp_r0 = !m_out && pend[0] && !exp_g;
            exp_r1 = !m_out && pend[1] &&  exp_g;
            exp_rv = m_out && (cyc >= m_acc + 2);
            chk("rnd_readies", {61'd0, rsp_valid, req0_ready, req1_ready}, {61'd0, exp_rv, exp_r0, exp_r1});
            chk("rnd_alu_ops", {alu_op1, alu_op2}, {m_a1, m_a2});
            chk("rnd_alu_func", {61'd0, alu_func}, {61'd0, m_f});
            if (exp_rv) begin
                chk("rnd_rsp", {27'd0, rsp_id, rsp_overflow, rsp_zero, rsp_equals, rsp_above, rsp_result},
                    {27'd0, m_id, m_exp});
                if (rsp_ready)
                    $display("rnd cyc=%0d rsp id=%0d result=%h", cyc, rsp_id, rsp_result);
            end
            if (exp_rv && rsp_ready) m_out = 1'b0;
            if (exp_r0 || exp_r1) begin
                m_out = 1'b1; m_acc = cyc; m_lg = exp_g; m_id = exp_g;
                m_a1 = pop1[exp_g]; m_a2 = pop2[exp_g]; m_f = pfunc[exp_g];
                m_exp = alu_model(m_a1, m_a2, m_f);
                pend[exp_g] = 1'b0;
            end
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
